// File: rtl/ccff_chain_loader_if.sv
// Host-side word interface of the configuration chain loader.
// The host (master) offers bitstream words with word_valid. The loader
// (slave) takes a word on any prog_clk edge where word_valid and
// word_ready are both high.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Configuration bitstream loader for a connection/switch block chain.
//
// Host words are taken from a valid/ready interface and shifted LSB-first
// into the chain through ccff_head. ccff_shift_en goes to the external
// clock gate, so the chain advances only on cycles that carry a real bit.
// Word 0 bit 0 enters first and ends up in the element nearest ccff_tail.
//
// Optional build macro CCFF_READBACK_CRC_EN adds a CRC-16-CCITT over the
// bits that leave ccff_tail during a load. This lets the host verify the
// previous chain contents. Without the macro, readback_crc is tied to 0.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 42,
  parameter int WORD_W    = 32
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               cfg_start,
  ccff_chain_loader_if.slave host,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  logic               ccff_tail,
  output logic               busy,
  output logic               done,
  output logic [15:0]        readback_crc
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_WORD = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]        state;
  logic [WORD_W-1:0] shreg;
  logic [BL_W-1:0]   bits_left;
  logic [WB_W-1:0]   word_bits;
  logic [WB_W-1:0]   word_take;

  // Number of bits to use from the next word: a full word, or only the
  // remainder of the chain on the last word.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    word_take = WB_W'(WORD_W);
    if (32'(bits_left) < WORD_W) begin
      word_take = WB_W'(bits_left);
    end
  end

  // Sequencer: start -> take word -> shift its bits -> next word or done.
  always_ff @(posedge prog_clk) begin
    // NOTE: the shift register and counters use the same synchronous reset as the state.
    // This keeps ccff_head and the counters deterministic after reset.
    if (pReset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bits_left <= '0;
      word_bits <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state     <= ST_WAIT_WORD;
            bits_left <= BL_W'(CHAIN_LEN);
          end
        end
        ST_WAIT_WORD: begin
          if (host.word_valid) begin
            shreg     <= host.word_data;
            word_bits <= word_take;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // NOTE: non-blocking assignments, so every branch below tests the pre-edge counter values.
          shreg     <= shreg >> 1;
          word_bits <= word_bits - WB_W'(1);
          bits_left <= bits_left - BL_W'(1);
          if (bits_left == BL_W'(1)) begin
            state <= ST_DONE;
          end else if (word_bits == WB_W'(1)) begin
            state <= ST_WAIT_WORD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All handshake and chain controls decode directly from the state. This
  // gives no extra latency, and shift_en drops on the same edge as a reset.
  assign host.word_ready = (state == ST_WAIT_WORD);
  assign ccff_shift_en   = (state == ST_SHIFT);
  assign ccff_head       = (state == ST_SHIFT) & shreg[0];
  assign busy            = (state == ST_WAIT_WORD) || (state == ST_SHIFT);
  assign done            = (state == ST_DONE);

`ifdef CCFF_READBACK_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_step;

  // One MSB-first CRC-16-CCITT step over the bit currently at ccff_tail.
  always_comb begin
    crc_step = {crc_q[14:0], 1'b0};
    if (crc_q[15] ^ ccff_tail) begin
      crc_step = crc_step ^ 16'h1021;
    end
  end

  // The CRC is reseeded when a load starts. It absorbs one tail bit per
  // shift and otherwise holds, so the result stays readable after done.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      crc_q <= 16'hFFFF;
    end else if (state == ST_IDLE && cfg_start) begin
      crc_q <= 16'hFFFF;
    end else if (state == ST_SHIFT) begin
      crc_q <= crc_step;
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign readback_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader.
// A behavioural chain model sits on ccff_head/ccff_tail. The expected chain
// contents, head bit order, load time and readback CRC come from the host
// words and the old chain contents. A second instance checks CHAIN_LEN=64.
module tb_ccff_chain_loader;

  localparam int CL  = 42;
  localparam int WW  = 32;
  localparam int NW  = (CL + WW - 1) / WW;
  localparam int CL2 = 64;
`ifdef CCFF_READBACK_CRC_EN
  localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
  localparam logic [15:0] CRC_RST = 16'h0000;
`endif

  logic        prog_clk;
  logic        pReset;
  logic        cfg_start;
  logic        ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic [15:0] readback_crc;

  logic        cfg_start64;
  logic        head64, shift64, tail64, busy64, done64;
  logic [15:0] crc64;

  ccff_chain_loader_if #(.WORD_W(WW)) host ();
  ccff_chain_loader_if #(.WORD_W(WW)) host64 ();

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .cfg_start     (cfg_start),
    .host          (host.slave),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .readback_crc  (readback_crc)
  );

  ccff_chain_loader #(.CHAIN_LEN(CL2), .WORD_W(WW)) dut64 (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .cfg_start     (cfg_start64),
    .host          (host64.slave),
    .ccff_head     (head64),
    .ccff_shift_en (shift64),
    .ccff_tail     (tail64),
    .busy          (busy64),
    .done          (done64),
    .readback_crc  (crc64)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Behavioural configuration chains. Element 0 is nearest ccff_tail.
  logic [CL-1:0]  chain, preload_val;
  logic           preload_req;
  logic [CL2-1:0] chain64, preload64_val;
  logic           preload64_req;
  assign ccff_tail = chain[0];
  assign tail64    = chain64[0];

  always @(posedge prog_clk) begin
    if (preload_req) chain <= preload_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
  end

  always @(posedge prog_clk) begin
    if (preload64_req) chain64 <= preload64_val;
    else if (shift64) chain64 <= {head64, chain64[CL2-1:1]};
  end

  // Monitor of the 42-bit instance.
  int   cyc_cnt   = 0;
  int   shift_cnt = 0;
  int   done_cnt  = 0;
  int   done_cyc  = 0;
  logic head_q[$];

  always @(posedge prog_clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge prog_clk) begin
    if (ccff_shift_en) begin
      head_q.push_back(ccff_head);
      shift_cnt <= shift_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc_cnt;
    end
  end

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] host_words[$];
  logic [CL-1:0] old_chain;
  int          ld_start, ld_sb, ld_db, ld_hb;

  // Reference: the chain ends up holding the bitstream, with bit i in element i.
  function automatic logic [CL-1:0] model_bits();
    logic [CL-1:0] b;
    logic [31:0]   w;
    b = '0;
    for (int i = 0; i < CL; i++) begin
      w    = host_words[i / WW];
      b[i] = w[i % WW];
    end
    return b;
  endfunction

  // Reference CRC-16-CCITT over the old contents, in the order they exit.
  function automatic logic [15:0] crc_model(input logic [CL-1:0] old);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < CL; i++) begin
      if (c[15] ^ old[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                c = {c[14:0], 1'b0};
    end
`ifdef CCFF_READBACK_CRC_EN
    return c;
`else
    return 16'h0000 & c;
`endif
  endfunction

  function automatic int head_errors();
    int bad;
    logic [CL-1:0] e;
    e   = model_bits();
    bad = 0;
    for (int i = 0; i < CL; i++) begin
      if (ld_hb + i >= head_q.size()) bad++;
      else if (head_q[ld_hb + i] !== e[i]) bad++;
    end
    return bad;
  endfunction

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(posedge prog_clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic random_words();
    host_words.delete();
    for (int i = 0; i < NW; i++) host_words.push_back($urandom());
  endtask

  // Host driver: start a load, offer each word after 'gap' idle WAIT cycles,
  // optionally pulse cfg_start mid-shift, then wait for done.
  task automatic run_load(input int gap, input bit poke, input bit chk_bp);
    int n;
    ld_sb = shift_cnt; ld_db = done_cnt; ld_hb = head_q.size();
    old_chain = chain;
    @(posedge prog_clk); #1 cfg_start = 1'b1;
    @(posedge prog_clk); #1 cfg_start = 1'b0;
    ld_start = cyc_cnt;
    for (int w = 0; w < host_words.size(); w++) begin
      n = 0;
      do begin
        @(negedge prog_clk);
        n++;
      end while (!host.word_ready && n < 200);
      if (!host.word_ready) begin
        checks++; failures++;
        $display("FAIL ready_timeout word=%0d waited=%0d cycles", w, n);
        return;
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge prog_clk);
        if (chk_bp) begin
          checks++;
          if (host.word_ready !== 1'b1 || ccff_shift_en !== 1'b0) begin
            failures++;
            $display("FAIL backpressure gap=%0d ready=%b shift_en=%b need ready=1 shift_en=0",
                     g, host.word_ready, ccff_shift_en);
          end
        end
      end
      host.word_data  = host_words[w];
      host.word_valid = 1'b1;
      @(posedge prog_clk); #1 host.word_valid = 1'b0;
      if (poke && w == 0) begin
        repeat (3) @(posedge prog_clk);
        #1 cfg_start = 1'b1;
        @(posedge prog_clk); #1 cfg_start = 1'b0;
      end
    end
    n = 0;
    while (done_cnt == ld_db && n < 400) begin
      @(negedge prog_clk); #1;
      n++;
    end
    if (done_cnt == ld_db) begin
      checks++; failures++;
      $display("FAIL done_timeout got no done pulse within %0d cycles", n);
    end
    repeat (3) @(negedge prog_clk);
    #1;
  endtask

  task automatic test_reset();
    pReset = 1'b1; cfg_start = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1;
    checks++;
    if ({host.word_ready, ccff_head, ccff_shift_en, busy, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got ready,head,sen,busy,done=%b need 00000",
               {host.word_ready, ccff_head, ccff_shift_en, busy, done});
    end
    checks++;
    if (readback_crc !== CRC_RST) begin
      failures++;
      $display("FAIL reset_crc got %h need %h", readback_crc, CRC_RST);
    end
    cfg_start = 1'b0;
    @(posedge prog_clk); #1 pReset = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      failures++;
      $display("FAIL reset_beats_start busy=%b done_cnt=%0d need busy=0 done_cnt=0", busy, done_cnt);
    end
  endtask

  task automatic test_basic();
    preload(CL'({$urandom(), $urandom()}));
    host_words.delete();
    host_words.push_back(32'hA5A5_A5A5);
    host_words.push_back(32'h0000_03C1);
    run_load(0, 1'b0, 1'b0);
    checks++;
    if (shift_cnt - ld_sb != CL) begin
      failures++; $display("FAIL basic_shifts got %0d need %0d", shift_cnt - ld_sb, CL);
    end
    checks++;
    if (head_errors() != 0) begin
      failures++; $display("FAIL basic_head_seq wrong_bits=%0d need 0", head_errors());
    end
    checks++;
    if (done_cnt - ld_db != 1 || done_cyc - ld_start != CL + NW) begin
      failures++;
      $display("FAIL basic_done pulses=%0d at=%0d need 1 at %0d", done_cnt - ld_db, done_cyc - ld_start, CL + NW);
    end
    checks++;
    if (chain !== model_bits()) begin
      failures++; $display("FAIL basic_chain got %h need %h", chain, model_bits());
    end
    checks++;
    if (readback_crc !== crc_model(old_chain)) begin
      failures++; $display("FAIL basic_crc got %h need %h", readback_crc, crc_model(old_chain));
    end
  endtask

  task automatic test_backpressure();
    preload(CL'({$urandom(), $urandom()}));
    host_words.delete();
    host_words.push_back(32'hA5A5_A5A5);
    host_words.push_back(32'h0000_03C1);
    run_load(5, 1'b0, 1'b1);
    checks++;
    if (chain !== model_bits() || shift_cnt - ld_sb != CL) begin
      failures++;
      $display("FAIL bp_chain got %h shifts=%0d need %h shifts=%0d", chain, shift_cnt - ld_sb, model_bits(), CL);
    end
    checks++;
    if (done_cyc - ld_start != CL + NW + 5 * NW) begin
      failures++; $display("FAIL bp_done_time got %0d need %0d", done_cyc - ld_start, CL + NW + 5 * NW);
    end
  endtask

  task automatic test_reset_mid();
    int sb, db, n;
    preload(CL'({$urandom(), $urandom()}));
    random_words();
    sb = shift_cnt; db = done_cnt;
    @(posedge prog_clk); #1 cfg_start = 1'b1;
    @(posedge prog_clk); #1 cfg_start = 1'b0;
    host.word_data  = host_words[0];
    host.word_valid = 1'b1;
    n = 0;
    while (shift_cnt - sb < 20 && n < 200) begin
      @(negedge prog_clk); #1;
      n++;
    end
    pReset = 1'b1; host.word_valid = 1'b0;
    @(posedge prog_clk); #1;
    checks++;
    if (ccff_shift_en !== 1'b0 || busy !== 1'b0 || host.word_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs sen=%b busy=%b ready=%b done=%b need all 0",
               ccff_shift_en, busy, host.word_ready, done);
    end
    pReset = 1'b0;
    repeat (5) @(posedge prog_clk);
    #1;
    checks++;
    if (shift_cnt - sb != 20 || done_cnt != db) begin
      failures++;
      $display("FAIL midreset_abort shifts=%0d dones=%0d need 20 and 0", shift_cnt - sb, done_cnt - db);
    end
    random_words();
    run_load(0, 1'b0, 1'b0);
    checks++;
    if (chain !== model_bits() || done_cnt - ld_db != 1 || shift_cnt - ld_sb != CL) begin
      failures++;
      $display("FAIL midreset_reload chain=%h dones=%0d shifts=%0d need %h 1 %0d",
               chain, done_cnt - ld_db, shift_cnt - ld_sb, model_bits(), CL);
    end
  endtask

  task automatic test_start_ignored();
    preload(CL'({$urandom(), $urandom()}));
    random_words();
    run_load(0, 1'b1, 1'b0);
    checks++;
    if (shift_cnt - ld_sb != CL || done_cnt - ld_db != 1 || done_cyc - ld_start != CL + NW) begin
      failures++;
      $display("FAIL start_ignored shifts=%0d dones=%0d at=%0d need %0d 1 %0d",
               shift_cnt - ld_sb, done_cnt - ld_db, done_cyc - ld_start, CL, CL + NW);
    end
    checks++;
    if (chain !== model_bits()) begin
      failures++; $display("FAIL start_ignored_chain got %h need %h", chain, model_bits());
    end
  endtask

  task automatic test_crc_ones();
    logic [15:0] exp;
    preload({CL{1'b1}});
    random_words();
    run_load(0, 1'b0, 1'b0);
    exp = crc_model({CL{1'b1}});
    checks++;
    if (readback_crc !== exp) begin
      failures++; $display("FAIL crc_ones got %h need %h", readback_crc, exp);
    end
    repeat (6) @(posedge prog_clk);
    #1;
    checks++;
    if (readback_crc !== exp || busy !== 1'b0) begin
      failures++; $display("FAIL crc_hold got %h busy=%b need %h busy=0", readback_crc, busy, exp);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      preload(CL'({$urandom(), $urandom()}));
      random_words();
      run_load(int'($urandom_range(0, 3)), 1'b0, 1'b0);
      checks++;
      if (chain !== model_bits() || head_errors() != 0 || shift_cnt - ld_sb != CL) begin
        failures++;
        $display("FAIL random_load it=%0d chain=%h bad_head=%0d shifts=%0d need %h 0 %0d",
                 it, chain, head_errors(), shift_cnt - ld_sb, model_bits(), CL);
      end
      checks++;
      if (readback_crc !== crc_model(old_chain) || done_cnt - ld_db != 1) begin
        failures++;
        $display("FAIL random_crc it=%0d crc=%h dones=%0d need %h 1",
                 it, readback_crc, done_cnt - ld_db, crc_model(old_chain));
      end
    end
  endtask

  task automatic test_chain64();
    logic [31:0] wq[2];
    int acc, sh, dn, dcyc, st;
    wq[0] = $urandom(); wq[1] = $urandom();
    preload64_val = {$urandom(), $urandom()};
    preload64_req = 1'b1;
    @(posedge prog_clk); #1 preload64_req = 1'b0;
    acc = 0; sh = 0; dn = 0; dcyc = 0;
    @(posedge prog_clk); #1 cfg_start64 = 1'b1;
    @(posedge prog_clk); #1 cfg_start64 = 1'b0;
    st = cyc_cnt;
    host64.word_valid = 1'b1;
    for (int n = 0; n < 90; n++) begin
      @(negedge prog_clk);
      if (shift64) sh++;
      if (done64) begin dn++; dcyc = cyc_cnt; end
      if (host64.word_ready) begin
        host64.word_data = (acc < 2) ? wq[acc] : 32'hDEAD_BEEF;
        acc++;
      end
    end
    host64.word_valid = 1'b0;
    checks++;
    if (acc != 2 || sh != CL2) begin
      failures++; $display("FAIL chain64_counts accepted=%0d shifts=%0d need 2 %0d", acc, sh, CL2);
    end
    checks++;
    if (dn != 1 || dcyc - st != CL2 + 2) begin
      failures++; $display("FAIL chain64_done pulses=%0d at=%0d need 1 at %0d", dn, dcyc - st, CL2 + 2);
    end
    checks++;
    if (chain64 !== {wq[1], wq[0]} || busy64 !== 1'b0) begin
      failures++; $display("FAIL chain64_chain got %h busy=%b need %h busy=0", chain64, busy64, {wq[1], wq[0]});
    end
  endtask

  initial begin
    pReset            = 1'b1;
    cfg_start         = 1'b0;
    cfg_start64       = 1'b0;
    host.word_valid   = 1'b0;
    host.word_data    = '0;
    host64.word_valid = 1'b0;
    host64.word_data  = '0;
    preload_req       = 1'b0;
    preload_val       = '0;
    preload64_req     = 1'b0;
    preload64_val     = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_crc_ones();
    test_random();
    test_chain64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
